// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo
// Description : Single-clock synchronous byte FIFO with registered full/empty
//               flags, registered read data and a one-cycle read_valid strobe.
//               Read data appears on dout right after the edge that accepts
//               the read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclr,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  read_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   c_cnt_depth = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_cnt_one   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   c_cnt_zero  = '0;
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one   = (ADDR_WIDTH)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   cnt_q,  cnt_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rvalid_q;

    logic                  wr_acc;
    logic                  rd_acc;

    // A write into a full FIFO is legal only when a read frees a slot on the
    // same edge; sclr suppresses both transfers.
    assign wr_acc = wren & (~full_q | rden) & ~sclr;
    assign rd_acc = rden & ~empty_q & ~sclr;

    // Next-state for pointers, occupancy count and the registered flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (wr_acc) begin
            wptr_d = wptr_q + c_ptr_one;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + c_ptr_one;
        end
        if (wr_acc && !rd_acc) begin
            cnt_d = cnt_q + c_cnt_one;
        end else if (rd_acc && !wr_acc) begin
            cnt_d = cnt_q - c_cnt_one;
        end
        full_d  = (cnt_d == c_cnt_depth);
        empty_d = (cnt_d == c_cnt_zero);
    end

    // Storage array: no reset, contents survive reset and sclr.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= din;
        end
    end

    // Control state, flags and read data; reset/sclr discard all entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else if (sclr) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                // Reads the pre-edge word, so a full FIFO doing read+write
                // returns the oldest entry before it is overwritten.
                dout_q <= mem_q[rptr_q];
            end
        end
    end

    assign dout       = dout_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign read_valid = rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo
// Description : Self-checking bench for fifo against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo;

    logic       clk;
    logic       reset;
    logic       sclr;
    logic       wren;
    logic       rden;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       read_valid;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [7:0] model_q[$];
    logic [7:0] exp_dout = 8'h00;
    logic       exp_rv   = 1'b0;

    fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclr       (sclr),
        .wren       (wren),
        .rden       (rden),
        .din        (din),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .read_valid (read_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"},  dout, exp_dout);
        check({tag, ".rv"},    {7'd0, read_valid}, {7'd0, exp_rv});
        check({tag, ".full"},  {7'd0, full},  {7'd0, model_q.size() == 16});
        check({tag, ".empty"}, {7'd0, empty}, {7'd0, model_q.size() == 0});
    endtask

    task automatic model_clear();
        model_q.delete();
        exp_dout = 8'h00;
        exp_rv   = 1'b0;
    endtask

    // One clock cycle: drive, let the edge happen, update model, check.
    task automatic cyc(input string tag, input logic w, input logic r,
                       input logic [7:0] d, input logic s);
        bit was_full;
        bit was_empty;
        wren = w;
        rden = r;
        din  = d;
        sclr = s;
        was_full  = (model_q.size() == 16);
        was_empty = (model_q.size() == 0);
        @(posedge clk);
        if (s) begin
            model_clear();
        end else begin
            if (r && !was_empty) begin
                exp_dout = model_q.pop_front();
                exp_rv   = 1'b1;
            end else begin
                exp_rv   = 1'b0;
            end
            if (w && (!was_full || r)) model_q.push_back(d);
        end
        #1;
        check_all(tag);
        wren = 1'b0;
        rden = 1'b0;
        sclr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sclr  = 1'b0;
        wren  = 1'b0;
        rden  = 1'b0;
        din   = 8'h00;

        // 1: reset then idle
        #100;
        reset = 1'b0;
        #1;
        check_all("reset");
        cyc("idle", 1'b0, 1'b0, 8'h00, 1'b0);

        // 2: three writes, three reads, one read on empty
        cyc("w11", 1'b1, 1'b0, 8'h11, 1'b0);
        cyc("w22", 1'b1, 1'b0, 8'h22, 1'b0);
        cyc("w33", 1'b1, 1'b0, 8'h33, 1'b0);
        cyc("r1", 1'b0, 1'b1, 8'h00, 1'b0);
        check("r1.const", dout, 8'h11);
        cyc("r2", 1'b0, 1'b1, 8'h00, 1'b0);
        cyc("r3", 1'b0, 1'b1, 8'h00, 1'b0);
        check("r3.const", dout, 8'h33);
        cyc("r_empty", 1'b0, 1'b1, 8'h00, 1'b0);
        check("r_empty.const", {read_valid, dout[6:0]}, 8'h33);

        // 3: fill to 16, overflow attempt, drain
        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 1'b0, 8'(i), 1'b0);
        check("full.const", {7'd0, full}, 8'h01);
        cyc("overflow", 1'b1, 1'b0, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 1'b1, 8'h00, 1'b0);
        check("drain.last", dout, 8'h0F);

        // 4: simultaneous read/write while full
        for (int i = 0; i < 16; i++) cyc("fill2", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        cyc("rw_full", 1'b1, 1'b1, 8'h5A, 1'b0);
        check("rw_full.const", dout, 8'h40);
        for (int i = 0; i < 16; i++) cyc("drain2", 1'b0, 1'b1, 8'h00, 1'b0);
        check("drain2.last", dout, 8'h5A);

        // 5: simultaneous read/write while empty
        cyc("rw_empty", 1'b1, 1'b1, 8'h77, 1'b0);
        cyc("r77", 1'b0, 1'b1, 8'h00, 1'b0);
        check("r77.const", dout, 8'h77);

        // 6: random interleave across wrap-around
        for (int i = 0; i < 120; i++) begin
            cyc("rand", ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 55),
                8'($urandom), 1'b0);
        end
        for (int i = 0; i < 6; i++) cyc("prefill", 1'b1, 1'b0, 8'($urandom), 1'b0);
        cyc("sclr", 1'b1, 1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 5; i++) cyc("post_sclr", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        cyc("pre_reset_rd", 1'b0, 1'b1, 8'h00, 1'b0);

        // asynchronous reset asserted between edges
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        cyc("after_reset_rd", 1'b0, 1'b1, 8'h00, 1'b0);
        cyc("after_reset_w", 1'b1, 1'b0, 8'h99, 1'b0);
        cyc("after_reset_r", 1'b0, 1'b1, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
